cam_capture_scaler: RTL

- Parametrised next-generation capture block for the OV7670 camera path.
- Samples the camera DVP byte stream (pclk/href/vsync/data) entirely in the system clock domain and assembles pixels of 1 or 2 bytes.
- Optionally decimates by a power-of-two factor, then writes pixels into the frame buffer through a single write port.
- Adds continuous and single-shot capture modes, a frame-done pulse, a frame counter and line-length error detection; sits between the camera pins and the frame-buffer BRAM, beside SCCB_Interface.

---
 rtl/cam_capture_scaler_if.sv | 11 +
 rtl/cam_capture_scaler.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cam_capture_scaler_if.sv
// Frame-buffer write port driven by the capture block: one pixel word per we pulse.
interface cam_capture_scaler_if #(
   parameter int ADDR_WIDTH = 17
);
   logic                  we;
   logic [ADDR_WIDTH-1:0] wAddr;
   logic [15:0]           wData;

   modport master (output we, wAddr, wData);
   modport slave  (input  we, wAddr, wData);
endinterface

// File: rtl/cam_capture_scaler.sv
// DVP camera capture: oversamples pclk/href/vsync in clk, assembles 1- or 2-byte pixels,
// decimates by DECIM and writes the frame buffer through a single registered write port.
module cam_capture_scaler #(
   parameter int IMG_WIDTH  = 320,
   parameter int IMG_HEIGHT = 240,
   parameter int PIX_BYTES  = 2,
   parameter int DECIM      = 1,
   parameter int OUT_W      = IMG_WIDTH / DECIM,
   parameter int OUT_H      = IMG_HEIGHT / DECIM,
   parameter int ADDR_WIDTH = $clog2(OUT_W * OUT_H)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cap_en,
   input  logic                 single_shot,
   input  logic                 cap_start,
   input  logic                 pclk,
   input  logic                 href,
   input  logic                 vsync,
   input  logic [7:0]           data,
   cam_capture_scaler_if.master fb,
   output logic                 busy,
   output logic                 frame_done,
   output logic [15:0]          frame_cnt,
   output logic                 line_err
);
   localparam int CW = $clog2(IMG_WIDTH + 1);
   localparam int RW = $clog2(IMG_HEIGHT + 1);

   typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;
   state_t state_reg, state_next;

   logic [2:0]            pclk_sync_reg, href_sync_reg, vsync_sync_reg;
   logic [7:0]            data_s1_reg, data_s2_reg;
   logic                  phase_reg;
   logic [7:0]            hi_reg;
   logic [CW-1:0]         col_in_reg;
   logic [RW-1:0]         row_in_reg;
   logic [ADDR_WIDTH-1:0] wr_ptr_reg, line_base_reg, pend_addr_reg;
   logic [15:0]           pend_data_reg;
   logic                  pend_reg;

   logic pclk_rise, href_fall, vs_fall, vs_rise;
   assign pclk_rise = pclk_sync_reg[1] & ~pclk_sync_reg[2];
   assign href_fall = ~href_sync_reg[1] & href_sync_reg[2];
   assign vs_fall   = ~vsync_sync_reg[1] & vsync_sync_reg[2];
   assign vs_rise   = vsync_sync_reg[1] & ~vsync_sync_reg[2];

   assign busy       = (state_reg != IDLE);
   assign frame_done = (state_reg == DONE);

   logic          capturing, byte_ev, pix_done, col_ok, row_ok, row_kept, keep;
   logic [15:0]   pix_word;
   logic [CW-1:0] col_eff;

   always_comb begin
      capturing = (state_reg == CAPTURE);
      byte_ev   = capturing && pclk_rise && href_sync_reg[1];
      pix_done  = byte_ev && ((PIX_BYTES == 1) || phase_reg);
      pix_word  = (PIX_BYTES == 1) ? {8'h00, data_s2_reg} : {hi_reg, data_s2_reg};
      col_ok    = (32'(col_in_reg) < IMG_WIDTH);
      row_ok    = (32'(row_in_reg) < IMG_HEIGHT);
      row_kept  = row_ok && ((32'(row_in_reg) % DECIM) == 0);
      keep      = pix_done && col_ok && row_kept && ((32'(col_in_reg) % DECIM) == 0);
      // column count including a pixel that completes in the same cycle as href fall
      col_eff   = (pix_done && col_ok) ? col_in_reg + CW'(1) : col_in_reg;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (cap_en && (!single_shot || cap_start)) state_next = WAIT_VS;
         WAIT_VS: if (!cap_en) state_next = IDLE;
                  else if (vs_fall) state_next = CAPTURE;
         CAPTURE: if (vs_rise) state_next = DONE;
         DONE:    state_next = (cap_en && !single_shot) ? WAIT_VS : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pclk_sync_reg  <= '0;
         href_sync_reg  <= '0;
         vsync_sync_reg <= '0;
         data_s1_reg    <= '0;
         data_s2_reg    <= '0;
         phase_reg      <= 1'b0;
         hi_reg         <= '0;
         col_in_reg     <= '0;
         row_in_reg     <= '0;
         wr_ptr_reg     <= '0;
         line_base_reg  <= '0;
         pend_reg       <= 1'b0;
         pend_addr_reg  <= '0;
         pend_data_reg  <= '0;
         fb.we          <= 1'b0;
         fb.wAddr       <= '0;
         fb.wData       <= '0;
         frame_cnt      <= '0;
         line_err       <= 1'b0;
      end else begin
         pclk_sync_reg  <= {pclk_sync_reg[1:0], pclk};
         href_sync_reg  <= {href_sync_reg[1:0], href};
         vsync_sync_reg <= {vsync_sync_reg[1:0], vsync};
         data_s1_reg    <= data;
         data_s2_reg    <= data_s1_reg;
         line_err       <= 1'b0;

         if (state_reg == WAIT_VS && state_next == CAPTURE) begin
            col_in_reg    <= '0;
            row_in_reg    <= '0;
            phase_reg     <= 1'b0;
            wr_ptr_reg    <= '0;
            line_base_reg <= '0;
            fb.wAddr      <= '0;
         end

         // second pipeline stage: the write port only updates when a pixel is written
         fb.we    <= pend_reg;
         pend_reg <= keep;
         if (pend_reg) begin
            fb.wAddr <= pend_addr_reg;
            fb.wData <= pend_data_reg;
         end

         if (state_reg == DONE) frame_cnt <= frame_cnt + 16'd1;

         if (byte_ev) begin
            if (!phase_reg) hi_reg <= data_s2_reg;
            if (PIX_BYTES == 2) phase_reg <= ~phase_reg;
         end
         if (pix_done && col_ok) col_in_reg <= col_eff;
         if (keep) begin
            pend_addr_reg <= wr_ptr_reg;
            pend_data_reg <= pix_word;
            wr_ptr_reg    <= wr_ptr_reg + ADDR_WIDTH'(1);
         end

         // line end overrides the per-pixel updates above; the address realigns to the row base
         if (capturing && href_fall) begin
            line_err   <= (32'(col_eff) != IMG_WIDTH);
            col_in_reg <= '0;
            phase_reg  <= 1'b0;
            if (row_ok) row_in_reg <= row_in_reg + RW'(1);
            if (row_kept) begin
               line_base_reg <= line_base_reg + ADDR_WIDTH'(OUT_W);
               wr_ptr_reg    <= line_base_reg + ADDR_WIDTH'(OUT_W);
            end else begin
               wr_ptr_reg    <= line_base_reg;
            end
         end
      end
   end
endmodule
